eth_rx_parser: RTL and testbench

Receive-side frame parser on clk156. It sinks the 10G MAC receive AXI-stream and decodes the Ethernet, IPv4 and UDP headers of every frame. It applies destination-MAC filtering and reports one header record per accepted frame, plus good, bad and filtered counters. It is the receiving counterpart of the frame encapsulator that drives the MAC transmit stream, and sits between the MAC m_axis_rx port and user logic.

---
 rtl/eth_rx_parser.sv | 223 ++++++++++++++++++++++
 tb/tb_eth_rx_parser.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_parser.sv
// rtl/eth_rx_parser.sv - 10G MAC receive-stream parser for Ethernet/IPv4/UDP headers
// Decodes header fields per frame, filters on destination MAC and keeps good/bad/filtered counters.
module eth_rx_parser #(
  parameter logic [47:0] LOCAL_MAC_DEFAULT = 48'h00_0A_35_00_00_01,
  parameter int          CNT_W             = 32
) (
  input  logic             clk156,
  input  logic             eth_rst_n,
  input  logic             s_axis_rx_tvalid,
  input  logic [63:0]      s_axis_rx_tdata,
  input  logic [7:0]       s_axis_rx_tkeep,
  input  logic             s_axis_rx_tlast,
  input  logic             s_axis_rx_tuser,
  input  logic             cfg_mac_override,
  input  logic [47:0]      cfg_local_mac,
  input  logic             cfg_promisc,
  output logic             hdr_valid,
  output logic [47:0]      hdr_dst_mac,
  output logic [47:0]      hdr_src_mac,
  output logic [15:0]      hdr_ethertype,
  output logic             hdr_is_ipv4,
  output logic             hdr_is_udp,
  output logic [31:0]      hdr_ip_src,
  output logic [31:0]      hdr_ip_dst,
  output logic [15:0]      hdr_udp_sport,
  output logic [15:0]      hdr_udp_dport,
  output logic [15:0]      hdr_frame_len,
  output logic [CNT_W-1:0] rx_good_cnt,
  output logic [CNT_W-1:0] rx_bad_cnt,
  output logic [CNT_W-1:0] rx_filt_cnt
);

  typedef enum logic [1:0] {SYNC, IDLE, HDR, PAYLOAD} state_t;

  state_t      state, state_nxt;
  logic [2:0]  beat_cnt, beat_nxt;
  logic [16:0] len_acc, len_nxt, len_base, len_upd;
  logic [17:0] len_sum;
  logic [3:0]  beat_bytes;
  logic [15:0] fin_len;
  logic        fin, is_bad, is_filt, ipv4_c;
  logic [47:0] local_mac;
  logic [63:0] data_m;
  logic [7:0]  b [8];

  logic [47:0] sh_dst, sh_src, sh_dst_nxt, sh_src_nxt;
  logic [15:0] sh_eth, sh_eth_nxt, sh_sport, sh_sport_nxt, sh_dport, sh_dport_nxt;
  logic [7:0]  sh_vihl, sh_vihl_nxt, sh_proto, sh_proto_nxt;
  logic [31:0] sh_ipsrc, sh_ipsrc_nxt, sh_ipdst, sh_ipdst_nxt;

  // Bytes not enabled on the last beat read as zero so truncated fields stay empty
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      data_m[8*i +: 8] = (!s_axis_rx_tlast || s_axis_rx_tkeep[i]) ? s_axis_rx_tdata[8*i +: 8] : 8'h00;
      b[i]             = data_m[8*i +: 8];
    end
  end

  // 17-bit accumulator sticks at all-ones once it overflows, giving a saturated 16-bit length
  assign beat_bytes = s_axis_rx_tlast ? 4'($countones(s_axis_rx_tkeep)) : 4'd8;
  assign len_base   = (state == IDLE) ? 17'd0 : len_acc;
  assign len_sum    = {1'b0, len_base} + {14'd0, beat_bytes};
  assign len_upd    = len_sum[17] ? 17'h1FFFF : len_sum[16:0];
  assign fin_len    = len_upd[16] ? 16'hFFFF : len_upd[15:0];

  always_comb begin
    state_nxt    = state;
    beat_nxt     = beat_cnt;
    len_nxt      = len_acc;
    fin          = 1'b0;
    sh_dst_nxt   = sh_dst;
    sh_src_nxt   = sh_src;
    sh_eth_nxt   = sh_eth;
    sh_vihl_nxt  = sh_vihl;
    sh_proto_nxt = sh_proto;
    sh_ipsrc_nxt = sh_ipsrc;
    sh_ipdst_nxt = sh_ipdst;
    sh_sport_nxt = sh_sport;
    sh_dport_nxt = sh_dport;
    case (state)
      SYNC: begin
        if (s_axis_rx_tvalid && s_axis_rx_tlast) state_nxt = IDLE;
      end
      IDLE: begin
        if (s_axis_rx_tvalid) begin
          sh_dst_nxt   = {b[0], b[1], b[2], b[3], b[4], b[5]};
          sh_src_nxt   = {b[6], b[7], 32'h0};
          sh_eth_nxt   = '0;
          sh_vihl_nxt  = '0;
          sh_proto_nxt = '0;
          sh_ipsrc_nxt = '0;
          sh_ipdst_nxt = '0;
          sh_sport_nxt = '0;
          sh_dport_nxt = '0;
          len_nxt      = len_upd;
          if (s_axis_rx_tlast) begin
            fin = 1'b1;
          end else begin
            state_nxt = HDR;
            beat_nxt  = 3'd1;
          end
        end
      end
      HDR: begin
        if (s_axis_rx_tvalid) begin
          len_nxt = len_upd;
          case (beat_cnt)
            3'd1: begin
              sh_src_nxt[31:0] = {b[0], b[1], b[2], b[3]};
              sh_eth_nxt       = {b[4], b[5]};
              sh_vihl_nxt      = b[6];
            end
            3'd2: sh_proto_nxt = b[7];
            3'd3: begin
              sh_ipsrc_nxt        = {b[2], b[3], b[4], b[5]};
              sh_ipdst_nxt[31:16] = {b[6], b[7]};
            end
            default: begin
              sh_ipdst_nxt[15:0] = {b[0], b[1]};
              sh_sport_nxt       = {b[2], b[3]};
              sh_dport_nxt       = {b[4], b[5]};
            end
          endcase
          if (s_axis_rx_tlast) begin
            fin       = 1'b1;
            state_nxt = IDLE;
          end else if (beat_cnt == 3'd4) begin
            state_nxt = PAYLOAD;
          end else begin
            beat_nxt = beat_cnt + 3'd1;
          end
        end
      end
      PAYLOAD: begin
        if (s_axis_rx_tvalid) begin
          len_nxt = len_upd;
          if (s_axis_rx_tlast) begin
            fin       = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  assign local_mac = cfg_mac_override ? cfg_local_mac : LOCAL_MAC_DEFAULT;
  assign is_bad    = !s_axis_rx_tuser || (fin_len < 16'd14);
  assign is_filt   = !cfg_promisc && (sh_dst_nxt != local_mac) && (sh_dst_nxt != 48'hFFFF_FFFF_FFFF);
  assign ipv4_c    = (sh_eth_nxt == 16'h0800) && (sh_vihl_nxt == 8'h45) && (fin_len >= 16'd24);

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state    <= SYNC;
      beat_cnt <= '0;
      len_acc  <= '0;
      sh_dst   <= '0;
      sh_src   <= '0;
      sh_eth   <= '0;
      sh_vihl  <= '0;
      sh_proto <= '0;
      sh_ipsrc <= '0;
      sh_ipdst <= '0;
      sh_sport <= '0;
      sh_dport <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
      len_acc  <= len_nxt;
      sh_dst   <= sh_dst_nxt;
      sh_src   <= sh_src_nxt;
      sh_eth   <= sh_eth_nxt;
      sh_vihl  <= sh_vihl_nxt;
      sh_proto <= sh_proto_nxt;
      sh_ipsrc <= sh_ipsrc_nxt;
      sh_ipdst <= sh_ipdst_nxt;
      sh_sport <= sh_sport_nxt;
      sh_dport <= sh_dport_nxt;
    end
  end

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      hdr_valid     <= 1'b0;
      hdr_dst_mac   <= '0;
      hdr_src_mac   <= '0;
      hdr_ethertype <= '0;
      hdr_is_ipv4   <= 1'b0;
      hdr_is_udp    <= 1'b0;
      hdr_ip_src    <= '0;
      hdr_ip_dst    <= '0;
      hdr_udp_sport <= '0;
      hdr_udp_dport <= '0;
      hdr_frame_len <= '0;
      rx_good_cnt   <= '0;
      rx_bad_cnt    <= '0;
      rx_filt_cnt   <= '0;
    end else begin
      hdr_valid <= 1'b0;
      if (fin) begin
        if (is_bad) begin
          rx_bad_cnt <= rx_bad_cnt + CNT_W'(1);
        end else if (is_filt) begin
          rx_filt_cnt <= rx_filt_cnt + CNT_W'(1);
        end else begin
          hdr_valid     <= 1'b1;
          hdr_dst_mac   <= sh_dst_nxt;
          hdr_src_mac   <= sh_src_nxt;
          hdr_ethertype <= sh_eth_nxt;
          hdr_is_ipv4   <= ipv4_c;
          hdr_is_udp    <= ipv4_c && (sh_proto_nxt == 8'd17);
          hdr_ip_src    <= sh_ipsrc_nxt;
          hdr_ip_dst    <= sh_ipdst_nxt;
          hdr_udp_sport <= sh_sport_nxt;
          hdr_udp_dport <= sh_dport_nxt;
          hdr_frame_len <= fin_len;
          rx_good_cnt   <= rx_good_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_parser.sv
// tb/tb_eth_rx_parser.sv - directed scoreboard bench for eth_rx_parser
module tb_eth_rx_parser;

  localparam logic [47:0] LOCAL_MAC = 48'h00_0A_35_00_00_01;
  localparam logic [47:0] SRC_MAC   = 48'h02_AA_BB_CC_DD_EE;
  localparam logic [47:0] BCAST     = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] OTHER_MAC = 48'h00_11_22_33_44_55;

  logic        clk156 = 1'b0;
  logic        eth_rst_n = 1'b0;
  logic        s_axis_rx_tvalid = 1'b0;
  logic [63:0] s_axis_rx_tdata = '0;
  logic [7:0]  s_axis_rx_tkeep = '0;
  logic        s_axis_rx_tlast = 1'b0;
  logic        s_axis_rx_tuser = 1'b0;
  logic        cfg_mac_override = 1'b0;
  logic [47:0] cfg_local_mac = 48'h02_00_00_00_00_77;
  logic        cfg_promisc = 1'b0;
  logic        hdr_valid;
  logic [47:0] hdr_dst_mac, hdr_src_mac;
  logic [15:0] hdr_ethertype;
  logic        hdr_is_ipv4, hdr_is_udp;
  logic [31:0] hdr_ip_src, hdr_ip_dst;
  logic [15:0] hdr_udp_sport, hdr_udp_dport, hdr_frame_len;
  logic [31:0] rx_good_cnt, rx_bad_cnt, rx_filt_cnt;

  eth_rx_parser dut (
    .clk156(clk156), .eth_rst_n(eth_rst_n),
    .s_axis_rx_tvalid(s_axis_rx_tvalid), .s_axis_rx_tdata(s_axis_rx_tdata),
    .s_axis_rx_tkeep(s_axis_rx_tkeep), .s_axis_rx_tlast(s_axis_rx_tlast),
    .s_axis_rx_tuser(s_axis_rx_tuser),
    .cfg_mac_override(cfg_mac_override), .cfg_local_mac(cfg_local_mac), .cfg_promisc(cfg_promisc),
    .hdr_valid(hdr_valid), .hdr_dst_mac(hdr_dst_mac), .hdr_src_mac(hdr_src_mac),
    .hdr_ethertype(hdr_ethertype), .hdr_is_ipv4(hdr_is_ipv4), .hdr_is_udp(hdr_is_udp),
    .hdr_ip_src(hdr_ip_src), .hdr_ip_dst(hdr_ip_dst),
    .hdr_udp_sport(hdr_udp_sport), .hdr_udp_dport(hdr_udp_dport), .hdr_frame_len(hdr_frame_len),
    .rx_good_cnt(rx_good_cnt), .rx_bad_cnt(rx_bad_cnt), .rx_filt_cnt(rx_filt_cnt)
  );

  always #3 clk156 = ~clk156;

  typedef struct {
    logic [47:0] dst, src;
    logic [15:0] eth;
    logic        ipv4, udp;
    logic [31:0] ips, ipd;
    logic [15:0] sp, dp, len;
  } rec_t;

  rec_t        exp_q[$];
  logic [7:0]  fb[$];
  int          checks = 0, errors = 0;
  int          exp_good = 0, exp_bad = 0, exp_filt = 0;
  logic        tl_d = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk156) tl_d <= s_axis_rx_tvalid & s_axis_rx_tlast;

  always @(negedge clk156) begin
    if (eth_rst_n && hdr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_hdr_valid", 64'(hdr_valid), 64'd0);
      end else begin
        rec_t r;
        r = exp_q.pop_front();
        chk("hdr_latency", 64'(tl_d), 64'd1);
        chk("dst_mac", 64'(hdr_dst_mac), 64'(r.dst));
        chk("src_mac", 64'(hdr_src_mac), 64'(r.src));
        chk("ethertype", 64'(hdr_ethertype), 64'(r.eth));
        chk("is_ipv4", 64'(hdr_is_ipv4), 64'(r.ipv4));
        chk("is_udp", 64'(hdr_is_udp), 64'(r.udp));
        chk("ip_src", 64'(hdr_ip_src), 64'(r.ips));
        chk("ip_dst", 64'(hdr_ip_dst), 64'(r.ipd));
        chk("udp_sport", 64'(hdr_udp_sport), 64'(r.sp));
        chk("udp_dport", 64'(hdr_udp_dport), 64'(r.dp));
        chk("frame_len", 64'(hdr_frame_len), 64'(r.len));
      end
    end
  end

  task automatic put_n(input int pos, input logic [63:0] v, input int n);
    for (int k = 0; k < n; k++)
      if (pos + k < fb.size()) fb[pos+k] = v[8*(n-1-k) +: 8];
  endtask

  task automatic build(input int len, input logic [47:0] dst, input logic [15:0] eth,
                       input logic [7:0] vihl, input logic [7:0] proto,
                       input logic [31:0] ips, input logic [31:0] ipd,
                       input logic [15:0] sp, input logic [15:0] dp);
    fb.delete();
    for (int i = 0; i < len; i++) fb.push_back(8'(i * 7 + 3));
    put_n(0, 64'(dst), 6);
    put_n(6, 64'(SRC_MAC), 6);
    put_n(12, 64'(eth), 2);
    put_n(14, 64'(vihl), 1);
    put_n(23, 64'(proto), 1);
    put_n(26, 64'(ips), 4);
    put_n(30, 64'(ipd), 4);
    put_n(34, 64'(sp), 2);
    put_n(36, 64'(dp), 2);
  endtask

  function automatic logic [7:0] gb(input int i);
    return (i < fb.size()) ? fb[i] : 8'h00;
  endfunction

  function automatic rec_t model();
    rec_t r;
    int   n = fb.size();
    r.dst  = {gb(0), gb(1), gb(2), gb(3), gb(4), gb(5)};
    r.src  = {gb(6), gb(7), gb(8), gb(9), gb(10), gb(11)};
    r.eth  = {gb(12), gb(13)};
    r.ipv4 = (n >= 24) && (r.eth == 16'h0800) && (gb(14) == 8'h45);
    r.udp  = r.ipv4 && (gb(23) == 8'd17);
    r.ips  = {gb(26), gb(27), gb(28), gb(29)};
    r.ipd  = {gb(30), gb(31), gb(32), gb(33)};
    r.sp   = {gb(34), gb(35)};
    r.dp   = {gb(36), gb(37)};
    r.len  = (n > 65535) ? 16'hFFFF : 16'(n);
    return r;
  endfunction

  task automatic send_frame(input bit tuser, input bit gaps, input int rst_beat);
    int len = fb.size();
    int nb  = (len + 7) / 8;
    for (int i = 0; i < nb; i++) begin
      if (gaps && i > 0) begin
        int g = $urandom_range(0, 2);
        repeat (g) begin
          @(posedge clk156); #1;
          s_axis_rx_tvalid = 1'b0;
          s_axis_rx_tlast  = 1'b0;
        end
      end
      @(posedge clk156); #1;
      s_axis_rx_tvalid = 1'b1;
      s_axis_rx_tlast  = (i == nb - 1);
      s_axis_rx_tuser  = (i == nb - 1) ? tuser : 1'b0;
      s_axis_rx_tkeep  = 8'hFF;
      for (int j = 0; j < 8; j++) begin
        if (8*i + j < len) begin
          s_axis_rx_tdata[8*j +: 8] = fb[8*i + j];
        end else begin
          s_axis_rx_tdata[8*j +: 8] = 8'hEE;
          s_axis_rx_tkeep[j]        = 1'b0;
        end
      end
      if (i == rst_beat) begin
        #1 eth_rst_n = 1'b0;
        #1;
        chk("rst_hdr_valid", 64'(hdr_valid), 64'd0);
        chk("rst_ip_src", 64'(hdr_ip_src), 64'd0);
        chk("rst_frame_len", 64'(hdr_frame_len), 64'd0);
        chk("rst_good_cnt", 64'(rx_good_cnt), 64'd0);
        chk("rst_bad_cnt", 64'(rx_bad_cnt), 64'd0);
        chk("rst_filt_cnt", 64'(rx_filt_cnt), 64'd0);
        @(posedge clk156); #1;
        eth_rst_n = 1'b1;
        exp_good = 0; exp_bad = 0; exp_filt = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk156); #1;
      s_axis_rx_tvalid = 1'b0;
      s_axis_rx_tlast  = 1'b0;
      s_axis_rx_tuser  = 1'b0;
    end
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk156);
    chk({tag, "_good"}, 64'(rx_good_cnt), 64'(exp_good));
    chk({tag, "_bad"}, 64'(rx_bad_cnt), 64'(exp_bad));
    chk({tag, "_filt"}, 64'(rx_filt_cnt), 64'(exp_filt));
  endtask

  task automatic build_udp(input logic [47:0] dst);
    build(64, dst, 16'h0800, 8'h45, 8'd17, 32'h0A000001, 32'h0A000002, 16'h1234, 16'h5678);
  endtask

  initial begin
    rec_t r;
    #20;
    chk("reset_hdr_valid", 64'(hdr_valid), 64'd0);
    chk("reset_dst_mac", 64'(hdr_dst_mac), 64'd0);
    chk("reset_is_udp", 64'(hdr_is_udp), 64'd0);
    chk("reset_frame_len", 64'(hdr_frame_len), 64'd0);
    check_counts("reset");
    eth_rst_n = 1'b1;
    idle(2);

    // After reset the parser waits for an end-of-frame; this frame is swallowed
    build(8, LOCAL_MAC, 16'h0800, 8'h45, 8'd17, 0, 0, 0, 0);
    send_frame(1'b1, 1'b0, -1);
    idle(3);
    check_counts("sync_flush");

    build_udp(LOCAL_MAC);
    r = '{dst: LOCAL_MAC, src: SRC_MAC, eth: 16'h0800, ipv4: 1'b1, udp: 1'b1,
          ips: 32'h0A000001, ipd: 32'h0A000002, sp: 16'h1234, dp: 16'h5678, len: 16'd64};
    exp_q.push_back(r);
    send_frame(1'b1, 1'b0, -1);
    idle(3);
    exp_good++;
    check_counts("udp64");

    build(64, LOCAL_MAC, 16'h0800, 8'h45, 8'd6, 32'hC0A80001, 32'hC0A80002, 16'h1111, 16'h2222);
    send_frame(1'b0, 1'b0, -1);
    idle(3);
    exp_bad++;
    check_counts("tuser_bad");
    chk("held_ip_src", 64'(hdr_ip_src), 64'h0A000001);
    chk("held_dport", 64'(hdr_udp_dport), 64'h5678);

    build(12, LOCAL_MAC, 16'h0800, 8'h45, 8'd17, 0, 0, 0, 0);
    send_frame(1'b1, 1'b0, -1);
    idle(3);
    exp_bad++;
    check_counts("len12");

    build(13, LOCAL_MAC, 16'h0800, 8'h45, 8'd17, 0, 0, 0, 0);
    send_frame(1'b1, 1'b0, -1);
    idle(3);
    exp_bad++;
    check_counts("len13");

    build(14, LOCAL_MAC, 16'h0800, 8'h45, 8'd17, 0, 0, 0, 0);
    exp_q.push_back(model());
    send_frame(1'b1, 1'b0, -1);
    idle(3);
    exp_good++;
    check_counts("len14");

    build(20, LOCAL_MAC, 16'h0800, 8'h45, 8'd17, 32'h01020304, 0, 0, 0);
    exp_q.push_back(model());
    send_frame(1'b1, 1'b0, -1);
    idle(3);
    exp_good++;
    check_counts("len20");

    build_udp(OTHER_MAC);
    send_frame(1'b1, 1'b0, -1);
    idle(3);
    exp_filt++;
    check_counts("filtered");

    cfg_promisc = 1'b1;
    exp_q.push_back(model());
    send_frame(1'b1, 1'b0, -1);
    idle(3);
    exp_good++;
    check_counts("promisc");
    cfg_promisc = 1'b0;

    build_udp(BCAST);
    exp_q.push_back(model());
    send_frame(1'b1, 1'b1, -1);
    idle(3);
    exp_good++;
    check_counts("broadcast");

    cfg_mac_override = 1'b1;
    build_udp(cfg_local_mac);
    exp_q.push_back(model());
    send_frame(1'b1, 1'b0, -1);
    idle(3);
    exp_good++;
    check_counts("override");
    cfg_mac_override = 1'b0;
    send_frame(1'b1, 1'b0, -1);
    idle(3);
    exp_filt++;
    check_counts("override_off");

    build(60, BCAST, 16'h0806, 8'h00, 8'h01, 0, 0, 0, 0);
    exp_q.push_back(model());
    send_frame(1'b1, 1'b1, -1);
    build(60, LOCAL_MAC, 16'h0806, 8'h00, 8'h02, 0, 0, 0, 0);
    exp_q.push_back(model());
    send_frame(1'b1, 1'b1, -1);
    idle(3);
    exp_good += 2;
    check_counts("arp_b2b");
    chk("arp_is_ipv4", 64'(hdr_is_ipv4), 64'd0);
    chk("arp_frame_len", 64'(hdr_frame_len), 64'd60);

    build_udp(LOCAL_MAC);
    send_frame(1'b1, 1'b0, 2);
    idle(3);
    check_counts("mid_reset");
    exp_q.push_back(model());
    send_frame(1'b1, 1'b0, -1);
    idle(3);
    exp_good++;
    check_counts("after_reset");

    build(9000, LOCAL_MAC, 16'h0800, 8'h45, 8'd17, 32'h0A000009, 32'h0A00000A, 16'h0009, 16'h000A);
    exp_q.push_back(model());
    send_frame(1'b1, 1'b0, -1);
    idle(3);
    exp_good++;
    check_counts("jumbo");
    chk("jumbo_len", 64'(hdr_frame_len), 64'd9000);

    build(70000, LOCAL_MAC, 16'h0800, 8'h45, 8'd17, 32'h0A00000B, 32'h0A00000C, 16'h000B, 16'h000C);
    exp_q.push_back(model());
    send_frame(1'b1, 1'b0, -1);
    idle(3);
    exp_good++;
    check_counts("huge");
    chk("huge_len_sat", 64'(hdr_frame_len), 64'hFFFF);

    idle(5);
    chk("pending_records", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
